fighter_state_machine: RTL

- Consumes the 7-bit `controller_inputs` word that the controller block produces, and turns it into per-frame fighter behaviour: walk, jump with gravity, crouch, attack and shield.
- Produces position, action state and hitbox flags, which the VGA sprite/bitchange logic uses for rendering and the hit-detection logic uses for scoring.
- One instance per player, clocked on the system clock and advanced only on `frame_tick`.

---
 rtl/fighter_pkg.sv | 40 ++++
 rtl/fighter_attack_timer.sv | 55 +++++
 rtl/fighter_state_machine.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/fighter_pkg.sv
// Shared constants for the fighter block: state encodings, controller bit
// positions, screen geometry and the x clamp helper.
package fighter_pkg;

  // Fighter state encodings (fighter_state output).
  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StWalk   = 3'd1;
  localparam logic [2:0] StJump   = 3'd2;
  localparam logic [2:0] StCrouch = 3'd3;
  localparam logic [2:0] StAttack = 3'd4;
  localparam logic [2:0] StShield = 3'd5;

  // Bit positions inside controller_inputs. Bit 6 is reserved.
  localparam int unsigned BtnLeft   = 0;
  localparam int unsigned BtnRight  = 1;
  localparam int unsigned BtnUp     = 2;
  localparam int unsigned BtnDown   = 3;
  localparam int unsigned BtnAttack = 4;
  localparam int unsigned BtnShield = 5;

  // Screen geometry.
  localparam int unsigned ScreenWidth  = 640;
  localparam int unsigned ScreenHeight = 480;
  localparam int unsigned SpriteWidth  = 64;

  // Clamp a signed 11-bit candidate x into [x_min, x_max]; negative values
  // land on x_min instead of wrapping.
  function automatic logic [9:0] clamp_x(input logic signed [10:0] x,
                                         input logic [9:0] x_min,
                                         input logic [9:0] x_max);
    if (x < $signed({1'b0, x_min})) begin
      return x_min;
    end else if (x > $signed({1'b0, x_max})) begin
      return x_max;
    end else begin
      return x[9:0];
    end
  endfunction

endpackage

// File: rtl/fighter_attack_timer.sv
// Attack frame counter.
//   clk, rst    : system clock, async active-high reset
//   frame_tick  : advance strobe, one cycle per video frame
//   start       : begin a new attack on this tick (counter restarts at 0)
//   active      : counter sits inside [ACTIVE_START, ACTIVE_END)
//   done        : pulses on the tick the counter reaches ATTACK_FRAMES-1
module fighter_attack_timer #(
  parameter int unsigned ATTACK_FRAMES = 12,
  parameter int unsigned ACTIVE_START  = 4,
  parameter int unsigned ACTIVE_END    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic frame_tick,
  input  logic start,
  output logic active,
  output logic done
);
  localparam int unsigned CntW = (ATTACK_FRAMES > 1) ? $clog2(ATTACK_FRAMES) : 1;

  logic [CntW-1:0] count_q, count_d;
  logic            busy_q, busy_d;
  logic            last;

  assign last   = busy_q && (32'(count_q) == ATTACK_FRAMES - 1);
  assign done   = frame_tick && last;
  assign active = busy_q && (32'(count_q) >= ACTIVE_START) && (32'(count_q) < ACTIVE_END);

  always_comb begin
    count_d = count_q;
    busy_d  = busy_q;
    if (frame_tick) begin
      if (start) begin
        count_d = '0;
        busy_d  = 1'b1;
      end else if (last) begin
        count_d = '0;
        busy_d  = 1'b0;
      end else if (busy_q) begin
        count_d = count_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: rtl/fighter_state_machine.sv
// Per-player fighter behaviour: walk, jump with gravity, crouch, attack, shield.
// All updates happen on frame_tick; every output comes straight from a register.
//   clk, rst          : system clock, async active-high reset
//   frame_tick        : one-cycle pulse per video frame
//   controller_inputs : [0] left [1] right [2] up [3] down [4] attack [5] shield
//   pos_x, pos_y      : sprite position (y grows downward)
//   fighter_state     : state encoding from fighter_pkg
//   facing_right      : 1 when facing right
//   attack_active     : hitbox live
//   shield_active     : blocking
module fighter_state_machine
  import fighter_pkg::*;
#(
  parameter int unsigned X_INIT        = 100,
  parameter int unsigned X_MIN         = 0,
  parameter int unsigned X_MAX         = 576,
  parameter int unsigned GROUND_Y      = 400,
  parameter int unsigned WALK_SPEED    = 2,
  parameter int unsigned JUMP_VEL      = 12,
  parameter int unsigned GRAVITY       = 1,
  parameter int unsigned ATTACK_FRAMES = 12,
  parameter int unsigned ACTIVE_START  = 4,
  parameter int unsigned ACTIVE_END    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [6:0] controller_inputs,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic [2:0] fighter_state,
  output logic       facing_right,
  output logic       attack_active,
  output logic       shield_active
);

  logic [2:0]        state_q, state_d;
  logic [9:0]        pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic signed [5:0] vel_y_q, vel_y_d;
  logic              facing_q, facing_d;
  logic              attack_prev_q, attack_prev_d;
  logic              attack_active_q, attack_active_d;
  logic              shield_active_q, shield_active_d;

  logic btn_left, btn_right, btn_up, btn_down, btn_attack, btn_shield;
  logic unused_reserved;
  assign btn_left        = controller_inputs[BtnLeft];
  assign btn_right       = controller_inputs[BtnRight];
  assign btn_up          = controller_inputs[BtnUp];
  assign btn_down        = controller_inputs[BtnDown];
  assign btn_attack      = controller_inputs[BtnAttack];
  assign btn_shield      = controller_inputs[BtnShield];
  assign unused_reserved = controller_inputs[6];

  logic grounded, attack_edge, atk_window, atk_done;
  assign grounded    = (state_q == StIdle) || (state_q == StWalk) || (state_q == StCrouch);
  assign attack_edge = btn_attack && !attack_prev_q;

  fighter_attack_timer #(
    .ATTACK_FRAMES(ATTACK_FRAMES),
    .ACTIVE_START (ACTIVE_START),
    .ACTIVE_END   (ACTIVE_END)
  ) u_attack_timer (
    .clk       (clk),
    .rst       (rst),
    .frame_tick(frame_tick),
    .start     (grounded && attack_edge),
    .active    (atk_window),
    .done      (atk_done)
  );

  // Horizontal datapath in 11-bit signed so a step below 0 clamps, not wraps.
  logic signed [10:0] x_ext, x_step;
  logic [9:0]         x_left, x_right, x_steer;
  assign x_ext   = $signed({1'b0, pos_x_q});
  assign x_step  = $signed(11'(WALK_SPEED));
  assign x_left  = clamp_x(x_ext - x_step, 10'(X_MIN), 10'(X_MAX));
  assign x_right = clamp_x(x_ext + x_step, 10'(X_MIN), 10'(X_MAX));
  assign x_steer = (btn_left && !btn_right) ? x_left :
                   (btn_right && !btn_left) ? x_right : pos_x_q;

  // Vertical datapath: positive vel_y moves the sprite up the screen.
  logic signed [10:0] y_next;
  assign y_next = $signed({1'b0, pos_y_q}) - $signed({{5{vel_y_q[5]}}, vel_y_q});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= StIdle;
      pos_x_q         <= 10'(X_INIT);
      pos_y_q         <= 10'(GROUND_Y);
      vel_y_q         <= '0;
      facing_q        <= 1'b1;
      attack_prev_q   <= 1'b0;
      attack_active_q <= 1'b0;
      shield_active_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      pos_x_q         <= pos_x_d;
      pos_y_q         <= pos_y_d;
      vel_y_q         <= vel_y_d;
      facing_q        <= facing_d;
      attack_prev_q   <= attack_prev_d;
      attack_active_q <= attack_active_d;
      shield_active_q <= shield_active_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pos_x_d  = pos_x_q;
    pos_y_d  = pos_y_q;
    vel_y_d  = vel_y_q;
    facing_d = facing_q;
    if (frame_tick) begin
      case (state_q)
        StIdle, StWalk, StCrouch: begin
          if (attack_edge) begin
            state_d = StAttack;
          end else if (btn_shield) begin
            state_d = StShield;
          end else if (btn_up) begin
            state_d = StJump;
            vel_y_d = 6'(JUMP_VEL);
          end else if (btn_down) begin
            state_d = StCrouch;
          end else if (btn_left ^ btn_right) begin
            state_d  = StWalk;
            pos_x_d  = btn_left ? x_left : x_right;
            facing_d = btn_right;
          end else begin
            state_d = StIdle;
          end
        end
        StJump: begin
          pos_x_d = x_steer;
          if (y_next >= $signed(11'(GROUND_Y))) begin
            pos_y_d = 10'(GROUND_Y);
            vel_y_d = '0;
            state_d = StIdle;
          end else begin
            pos_y_d = y_next[9:0];
            vel_y_d = vel_y_q - $signed(6'(GRAVITY));
          end
        end
        StAttack: begin
          if (atk_done) state_d = StIdle;
        end
        StShield: begin
          if (!btn_shield) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Attack history tracks the button on every tick, even when the edge is ignored.
  always_comb begin
    attack_prev_d   = frame_tick ? btn_attack : attack_prev_q;
    attack_active_d = frame_tick ? atk_window : attack_active_q;
    shield_active_d = (state_d == StShield);
  end

  assign pos_x         = pos_x_q;
  assign pos_y         = pos_y_q;
  assign fighter_state = state_q;
  assign facing_right  = facing_q;
  assign attack_active = attack_active_q;
  assign shield_active = shield_active_q;

endmodule
